// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline sequencer.
// Imported by pipe_ctrl and its helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } fsm_t;

  localparam int CNT_W_DEF        = 16;
  localparam int DMEM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones.
// Async active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: merges stall/flush requests,
// owns HALT drain, wrong-path squash, stall count, dmem timeout.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             halt_id,
  input  logic             halt_wb,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_write,
  output logic             halted,
  output logic             dmem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  fsm_t       state;
  fsm_t       state_nxt;
  logic       squash;
  logic       squash_nxt;
  logic       live;
  logic       stall_en;
  logic [7:0] dmem_wait;
  logic [8:0] wait_inc;

  // live: pipe is neither stopped nor frozen by dmem
  assign live     = (state != HALTED) && !dmem_stall;
  assign wait_inc = {1'b0, dmem_wait} + 9'd1;
  assign stall_en = !pc_write && (state != HALTED) && !rst;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_write  = 1'b1;
    halted      = 1'b0;
    priority case (1'b1)
      rst: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        pipe_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      (state == HALTED): begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_write = 1'b0;
        halted     = 1'b1;
      end
      dmem_stall: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_write = 1'b0;
      end
      branch_taken: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      hazard_stall: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      imem_stall: begin
        pc_write   = 1'b0;
        ifid_flush = 1'b1;
      end
      (state == DRAIN): begin
        pc_write   = 1'b0;
        ifid_flush = 1'b1;
      end
      default: ;
    endcase
    // discard the wrong-path word returned by the old fetch
    if (!rst && live && squash && !imem_stall) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    squash_nxt = squash;
    if (live) begin
      if (branch_taken && imem_stall) begin
        squash_nxt = 1'b1;
      end else if (!imem_stall) begin
        squash_nxt = 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (halt_wb && !dmem_stall) begin
      state_nxt = HALTED;
    end else begin
      unique case (state)
        RUN: begin
          if (halt_id && ifid_write && !branch_taken) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (branch_taken) begin
            state_nxt = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      squash <= 1'b0;
    end else begin
      state  <= state_nxt;
      squash <= squash_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_wait <= '0;
      dmem_err  <= 1'b0;
    end else if (dmem_stall) begin
      if (dmem_wait != 8'hFF) begin
        dmem_wait <= wait_inc[7:0];
      end
      if (int'(wait_inc) >= DMEM_TIMEOUT) begin
        dmem_err <= 1'b1;
      end
    end else begin
      dmem_wait <= '0;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (stall_en),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a behavioural reference model.
// Small CNT_W and DMEM_TIMEOUT make saturation and timeout reachable.
module tb_pipe_ctrl;

  localparam int CW   = 4;
  localparam int TMO  = 4;
  localparam int CMAX = 15;

  localparam logic [5:0] H  = 6'b100000;
  localparam logic [5:0] B  = 6'b010000;
  localparam logic [5:0] I  = 6'b001000;
  localparam logic [5:0] D  = 6'b000100;
  localparam logic [5:0] HI = 6'b000010;
  localparam logic [5:0] HW = 6'b000001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hazard_stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic          imem_stall = 1'b0;
  logic          dmem_stall = 1'b0;
  logic          halt_id = 1'b0;
  logic          halt_wb = 1'b0;
  logic          pc_write;
  logic          ifid_write;
  logic          ifid_flush;
  logic          idex_bubble;
  logic          pipe_write;
  logic          halted;
  logic          dmem_err;
  logic [CW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // model state: mode 0=running, 1=draining, 2=stopped
  int m_mode  = 0;
  int m_cnt   = 0;
  int m_dwait = 0;
  bit m_sq    = 1'b0;
  bit m_err   = 1'b0;

  pipe_ctrl #(
    .CNT_W       (CW),
    .DMEM_TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hazard_stall(hazard_stall),
    .branch_taken(branch_taken),
    .imem_stall  (imem_stall),
    .dmem_stall  (dmem_stall),
    .halt_id     (halt_id),
    .halt_wb     (halt_wb),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .pipe_write  (pipe_write),
    .halted      (halted),
    .dmem_err    (dmem_err),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_write, halted}
  function automatic logic [5:0] expect_outs();
    logic [5:0] r;
    if (rst) return 6'b001100;
    if (m_mode == 2) return 6'b000001;
    if (dmem_stall) return 6'b000000;
    if (branch_taken) r = 6'b111110;
    else if (hazard_stall) r = 6'b000110;
    else if (imem_stall) r = 6'b011010;
    else if (m_mode == 1) r = 6'b011010;
    else r = 6'b110010;
    if (m_sq && !imem_stall) r[3] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [5:0] e;
    if (rst) begin
      m_mode  = 0;
      m_cnt   = 0;
      m_dwait = 0;
      m_sq    = 1'b0;
      m_err   = 1'b0;
    end else begin
      e = expect_outs();
      if (!e[5] && m_mode != 2 && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (dmem_stall) begin
        if (m_dwait < 255) m_dwait = m_dwait + 1;
        if (m_dwait >= TMO) m_err = 1'b1;
      end else begin
        m_dwait = 0;
      end
      if (m_mode != 2 && !dmem_stall) begin
        if (branch_taken && imem_stall) m_sq = 1'b1;
        else if (!imem_stall) m_sq = 1'b0;
      end
      if (halt_wb && !dmem_stall) m_mode = 2;
      else if (m_mode == 0 && halt_id && e[4] && !branch_taken) m_mode = 1;
      else if (m_mode == 1 && branch_taken) m_mode = 0;
    end
  end

  always @(negedge clk) begin
    logic [5:0] e;
    e = expect_outs();
    chk("pc_write", int'(pc_write), int'(e[5]));
    chk("ifid_write", int'(ifid_write), int'(e[4]));
    chk("ifid_flush", int'(ifid_flush), int'(e[3]));
    chk("idex_bubble", int'(idex_bubble), int'(e[2]));
    chk("pipe_write", int'(pipe_write), int'(e[1]));
    chk("halted", int'(halted), int'(e[0]));
    chk("stall_cnt", int'(stall_cnt), m_cnt);
    chk("dmem_err", int'(dmem_err), int'(m_err));
  end

  task automatic drive(input logic [5:0] v);
    @(posedge clk);
    #1;
    {hazard_stall, branch_taken, imem_stall,
     dmem_stall, halt_id, halt_wb} = v;
    @(negedge clk);
    #1;
  endtask

  initial begin
    drive(6'b0);
    chk("rst_pc", int'(pc_write), 0);
    chk("rst_flush", int'(ifid_flush), 1);
    chk("rst_bubble", int'(idex_bubble), 1);
    chk("rst_halted", int'(halted), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    rst = 1'b0;
    #1;
    chk("run_pc", int'(pc_write), 1);

    drive(H);
    chk("hz_pc", int'(pc_write), 0);
    chk("hz_ifw", int'(ifid_write), 0);
    chk("hz_bub", int'(idex_bubble), 1);
    chk("hz_pipe", int'(pipe_write), 1);
    drive(6'b0);
    chk("hz_cnt", int'(stall_cnt), 1);

    drive(B | I);
    chk("br_pc", int'(pc_write), 1);
    chk("br_bub", int'(idex_bubble), 1);
    drive(I);
    drive(I);
    drive(6'b0);
    chk("sq_flush", int'(ifid_flush), 1);
    chk("sq_pc", int'(pc_write), 1);
    drive(6'b0);
    chk("sq_done", int'(ifid_flush), 0);
    chk("sq_cnt", int'(stall_cnt), 3);

    repeat (4) drive(B | D);
    chk("frz_pc", int'(pc_write), 0);
    chk("frz_ifw", int'(ifid_write), 0);
    chk("frz_pipe", int'(pipe_write), 0);
    chk("frz_flush", int'(ifid_flush), 0);
    drive(B);
    chk("frz_br_flush", int'(ifid_flush), 1);
    chk("frz_br_pc", int'(pc_write), 1);
    chk("frz_cnt", int'(stall_cnt), 7);

    drive(HI);
    drive(6'b0);
    chk("drn_pc", int'(pc_write), 0);
    chk("drn_flush", int'(ifid_flush), 1);
    drive(6'b0);
    drive(B);
    drive(6'b0);
    chk("abort_pc", int'(pc_write), 1);
    chk("abort_flush", int'(ifid_flush), 0);
    chk("abort_cnt", int'(stall_cnt), 9);

    drive(HI);
    drive(6'b0);
    drive(6'b0);
    drive(HW);
    chk("hw_pc", int'(pc_write), 0);
    chk("hw_cnt", int'(stall_cnt), 11);
    drive(H);
    chk("hlt", int'(halted), 1);
    chk("hlt_pipe", int'(pipe_write), 0);
    chk("hlt_bub", int'(idex_bubble), 0);
    chk("hlt_cnt", int'(stall_cnt), 12);
    drive(D | B);
    chk("hlt_cnt2", int'(stall_cnt), 12);

    rst = 1'b1;
    #1;
    chk("rst2_halted", int'(halted), 0);
    drive(6'b0);
    rst = 1'b0;
    #1;
    drive(6'b0);
    chk("rel_pc", int'(pc_write), 1);
    chk("rel_cnt", int'(stall_cnt), 0);

    repeat (4) drive(D);
    chk("tmo_early", int'(dmem_err), 0);
    drive(D);
    chk("tmo_set", int'(dmem_err), 1);
    drive(D);
    drive(6'b0);
    chk("tmo_sticky", int'(dmem_err), 1);
    chk("tmo_cnt", int'(stall_cnt), 6);

    repeat (12) drive(H);
    drive(6'b0);
    chk("sat_cnt", int'(stall_cnt), 15);

    drive(HI);
    drive(6'b0);
    drive(6'b0);
    rst = 1'b1;
    #1;
    chk("rst3_pc", int'(pc_write), 0);
    chk("rst3_flush", int'(ifid_flush), 1);
    drive(6'b0);
    rst = 1'b0;
    #1;
    drive(6'b0);
    chk("rst3_run_pc", int'(pc_write), 1);
    chk("rst3_run_fl", int'(ifid_flush), 0);
    chk("rst3_cnt", int'(stall_cnt), 0);
    chk("rst3_err", int'(dmem_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Merges per-cycle stall and flush requests into one consistent set of pipeline-register enables, bubbles and flushes:
  - load-use/JALR stall from the hazard unit
  - taken-branch redirect from EX
  - multi-cycle instruction- and data-memory busy
  - HALT
- Owns the HALT drain sequence, a squash flag for in-flight wrong-path fetches, a stall-cycle counter and a data-memory timeout detector.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.
- DMEM_TIMEOUT, 255, consecutive dmem_stall cycles tolerated before dmem_err is raised (must be at least 1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- hazard_stall  in  1  load-use/JALR dependency stall request from the hazard unit
- branch_taken  in  1  control transfer resolved taken in EX; PC mux already selects the target
- imem_stall  in  1  instruction memory busy; fetch data not valid
- dmem_stall  in  1  data memory busy on the MEM-stage access
- halt_id  in  1  HALT instruction decoded in ID
- halt_wb  in  1  HALT instruction in MEM/WB
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  load NOP into IF/ID (applies only when ifid_write=1)
- idex_bubble  out  1  load control-zero bubble into ID/EX
- pipe_write  out  1  enable for ID/EX, EX/MEM and MEM/WB
- halted  out  1  core stopped
- dmem_err  out  1  sticky dmem timeout flag
- stall_cnt  out  CNT_W  cycles with pc_write=0 while not halted, saturating

Behaviour:
- Registered state:
  - fsm {RUN, DRAIN, HALTED}
  - squash_pending
  - stall_cnt
  - dmem_wait counter (8 bits)
  - dmem_err
- Reset (async): fsm=RUN, squash_pending=0, stall_cnt=0, dmem_wait=0, dmem_err=0.
- While rst=1, force: pc_write=0, ifid_write=0, pipe_write=0, ifid_flush=1, idex_bubble=1, halted=0.
- Enables are combinational from registered state plus current inputs (zero latency). Evaluate in strict priority; first match wins:
  1. fsm=HALTED: all enables 0, flush/bubble 0, halted=1.
  2. dmem_stall: pc_write=0, ifid_write=0, pipe_write=0, no flush/bubble. Whole pipe is frozen; a simultaneous branch_taken stays asserted because EX is held.
  3. branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, pipe_write=1.
     - Overrides hazard_stall and imem_stall.
     - If imem_stall=1 the same cycle, set squash_pending. The imem interface latches its address at request start, so the PC change is safe.
  4. hazard_stall: pc_write=0, ifid_write=0, idex_bubble=1, pipe_write=1.
  5. imem_stall: pc_write=0, ifid_write=1, ifid_flush=1, pipe_write=1.
  6. fsm=DRAIN: pc_write=0, ifid_write=1, ifid_flush=1, pipe_write=1. Stops fetch behind HALT.
  7. otherwise: all enables 1, no flush/bubble.
- squash_pending:
  - On the first cycle with imem_stall=0 and squash_pending=1, force ifid_flush=1 (the returned wrong-path instruction is discarded).
  - Clear squash_pending at that clock edge.
  - Unaffected while dmem_stall freezes the pipe.
- FSM transitions, evaluated at the clock edge; halt_wb has top priority:
  - Any state with halt_wb=1 and dmem_stall=0: go to HALTED.
  - RUN to DRAIN when halt_id=1 and ifid_write=1 this cycle and branch_taken=0. A halt_id on a branch-flushed slot is ignored.
  - DRAIN to RUN when branch_taken=1: the HALT was wrong-path and the drain is aborted.
  - HALTED is exited only by rst.
- stall_cnt: increments by 1 each cycle where pc_write=0, fsm!=HALTED and rst=0. Holds at all-ones (no wrap).
- dmem_wait: increments each cycle dmem_stall=1, resets to 0 when dmem_stall=0. When dmem_wait reaches DMEM_TIMEOUT, set dmem_err=1 (sticky until rst). The pipeline keeps waiting; the error is reported only.

Decomposition:
- Shared package (pipe_pkg):
  - fsm state encoding: RUN=2'b00, DRAIN=2'b01, HALTED=2'b10
  - default CNT_W and DMEM_TIMEOUT constants
- Sub-module sat_counter (parameter W): increment enable, saturate, async reset. Instantiated for stall_cnt.
- dmem_wait stays inline.

Test Plan:
- Reset mid-run: assert rst with fsm=DRAIN and stall_cnt=5 -> same cycle pc_write=0, ifid_flush=1; after release fsm=RUN, stall_cnt=0, dmem_err=0.
- hazard_stall=1 for 1 cycle, others 0 -> pc_write=0, ifid_write=0, idex_bubble=1, pipe_write=1; stall_cnt 0->1.
- branch_taken=1 with imem_stall=1 for 3 cycles (branch in cycle 1) -> cycle 1: pc_write=1, idex_bubble=1. Then squash_pending=1; first cycle imem_stall=0 gives ifid_flush=1; next cycle no flush.
- dmem_stall=1 with branch_taken=1 for 4 cycles -> all enables 0 for 4 cycles; cycle 5 (dmem_stall=0) applies the branch flush; stall_cnt=4.
- halt_id=1 -> DRAIN with ifid_flush=1 and pc_write=0 each cycle. Then branch_taken=1 -> fsm back to RUN. Repeat without branch, then halt_wb=1 -> halted=1, all enables 0, stall_cnt frozen.
- DMEM_TIMEOUT=4, hold dmem_stall=1 for 6 cycles -> dmem_err rises at the edge where dmem_wait reaches 4; stays 1 after dmem_stall drops.
